// File: rtl/axis_red_pitaya_dac_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_rp_dac_pkg
// Description : Shared encodings for the multi-channel Red Pitaya DAC block:
//               per-channel mode values, PRBS polynomial selects, the
//               polynomial length/tap table and the DAC word encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_rp_dac_pkg;

  typedef enum logic [1:0] {
    MODE_STREAM = 2'b00,
    MODE_PRBS   = 2'b01,
    MODE_CONST  = 2'b10,
    MODE_OFF    = 2'b11
  } dac_mode_e;

  typedef enum logic [1:0] {
    PRBS_7  = 2'b00,
    PRBS_15 = 2'b01,
    PRBS_23 = 2'b10,
    PRBS_31 = 2'b11
  } prbs_sel_e;

  // Register length and second feedback tap (1-based) of each polynomial.
  typedef struct packed {
    logic [4:0] len;
    logic [4:0] tap;
  } prbs_poly_t;

  function automatic prbs_poly_t prbs_poly(input logic [1:0] sel);
    prbs_poly_t p;
    case (sel)
      PRBS_7:  begin p.len = 5'd7;  p.tap = 5'd6;  end
      PRBS_15: begin p.len = 5'd15; p.tap = 5'd14; end
      PRBS_23: begin p.len = 5'd23; p.tap = 5'd18; end
      default: begin p.len = 5'd31; p.tap = 5'd28; end
    endcase
    return p;
  endfunction

  // All-ones seed confined to the active register length; doubles as the
  // mask that keeps unused upper LFSR bits at zero.
  function automatic logic [30:0] prbs_seed(input logic [1:0] sel);
    prbs_poly_t p;
    p = prbs_poly(sel);
    return 31'h7FFF_FFFF >> (5'd31 - p.len);
  endfunction

  // Two's complement to DAC offset-binary style word: keep the sign bit,
  // invert the magnitude bits. Bits at and above w are returned as zero.
  function automatic logic [15:0] encode(input logic [15:0] s, input int unsigned w);
    return (s ^ (16'hFFFF >> (17 - w))) & (16'hFFFF >> (16 - w));
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_red_pitaya_dac_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : axis_red_pitaya_dac_mc_if
// Description : AXI4-Stream sample bus, one 16-bit lane per DAC channel.
// Ports       : tdata  - NUM_CH x 16-bit lanes
//               tvalid - source has a sample set
//               tready - sink accepts this cycle
// Revision    : 1.0 - initial release
// ============================================================================
interface axis_red_pitaya_dac_mc_if #(
  parameter int NUM_CH = 2
) ();
  logic [16*NUM_CH-1:0] tdata;
  logic                 tvalid;
  logic                 tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_red_pitaya_dac_mc_prbs_gen.sv
`default_nettype none
// ============================================================================
// Module      : prbs_gen
// Description : Selectable-length Fibonacci LFSR with a bit-period divider.
// Ports       : aclk, aresetn        - clock, synchronous active-low reset
//               cfg_div              - step every cfg_div+1 cycles
//               cfg_prbs_sel         - polynomial select
//               prbs_restart         - reload seed, clear divider
//               prbs_bit, prbs_wrap  - current bit, return-to-seed pulse
// Revision    : 1.0 - initial release
// ============================================================================
module prbs_gen
  import axis_rp_dac_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  wire logic                 aclk,
  input  wire logic                 aresetn,
  input  wire logic [DIV_WIDTH-1:0] cfg_div,
  input  wire logic [1:0]           cfg_prbs_sel,
  input  wire logic                 prbs_restart,
  output logic                      prbs_bit,
  output logic                      prbs_wrap
);

  logic [30:0]          r_lfsr;
  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic [1:0]           r_sel;
  logic                 r_wrap;

  prbs_poly_t  w_poly;
  logic [30:0] w_seed;
  logic [30:0] w_lfsr_next;
  logic        w_fb;
  logic        w_step;
  logic        w_reload;

  assign w_poly      = prbs_poly(cfg_prbs_sel);
  assign w_seed      = prbs_seed(cfg_prbs_sel);
  assign w_fb        = r_lfsr[w_poly.len - 5'd1] ^ r_lfsr[w_poly.tap - 5'd1];
  assign w_lfsr_next = ((r_lfsr << 1) | {30'b0, w_fb}) & w_seed;
  // '>=' rather than '==' so that lowering cfg_div below the running
  // count still produces a step on the next cycle.
  assign w_step      = (r_div_cnt >= cfg_div);
  assign w_reload    = prbs_restart | (cfg_prbs_sel != r_sel);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_lfsr    <= w_seed;
      r_div_cnt <= '0;
      r_sel     <= cfg_prbs_sel;
      r_wrap    <= 1'b0;
    end else if (w_reload) begin
      r_lfsr    <= w_seed;
      r_div_cnt <= '0;
      r_sel     <= cfg_prbs_sel;
      r_wrap    <= 1'b0;
    end else if (w_step) begin
      r_lfsr    <= w_lfsr_next;
      r_div_cnt <= '0;
      r_wrap    <= (w_lfsr_next == w_seed);
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
      r_wrap    <= 1'b0;
    end
  end

  assign prbs_bit  = r_lfsr[w_poly.len - 5'd1];
  assign prbs_wrap = r_wrap;

endmodule
`default_nettype wire

// File: rtl/axis_red_pitaya_dac_mc.sv
`default_nettype none
// ============================================================================
// Module      : axis_red_pitaya_dac_mc
// Description : Multi-channel DAC front end. Each channel plays the stream
//               lane, a PRBS square wave, a constant or zero, and drives an
//               encoded DAC word one cycle later.
// Ports       : aclk, aresetn     - clock, synchronous active-low reset
//               s_axis            - AXI4-Stream slave (lanes per channel)
//               cfg_*             - mode, amplitude, divider, PRBS select, hold
//               prbs_restart      - restart pulse for the shared PRBS
//               cnt_clr           - clear pulse for underflow_cnt
//               dac_dat, dac_rst  - encoded words, DAC reset request
//               prbs_bit/_wrap    - shared PRBS status
//               underflow_cnt     - saturating stream underflow count
// Revision    : 1.0 - initial release
// ============================================================================
module axis_red_pitaya_dac_mc
  import axis_rp_dac_pkg::*;
#(
  parameter int DAC_DATA_WIDTH = 14,
  parameter int NUM_CH         = 2,
  parameter int DIV_WIDTH      = 8
) (
  input  wire logic                               aclk,
  input  wire logic                               aresetn,
  axis_red_pitaya_dac_mc_if.slave                 s_axis,
  input  wire logic [2*NUM_CH-1:0]                cfg_mode,
  input  wire logic [DAC_DATA_WIDTH-2:0]          cfg_amp,
  input  wire logic [DIV_WIDTH-1:0]               cfg_div,
  input  wire logic [1:0]                         cfg_prbs_sel,
  input  wire logic                               cfg_hold_en,
  input  wire logic                               prbs_restart,
  input  wire logic                               cnt_clr,
  output logic [NUM_CH*DAC_DATA_WIDTH-1:0]        dac_dat,
  output logic                                    dac_rst,
  output logic                                    prbs_bit,
  output logic                                    prbs_wrap,
  output logic [31:0]                             underflow_cnt
);

  localparam int W = DAC_DATA_WIDTH;

  logic              r_tready;
  logic              r_dac_rst;
  logic [31:0]       r_underflow_cnt;
  logic              w_prbs_bit;
  logic              w_accept;
  logic              w_underflow;
  logic [NUM_CH-1:0] w_is_stream;
  logic [W-1:0]      w_amp_pos;
  logic [W-1:0]      w_amp_neg;
  logic [W-1:0]      w_enc_pos;
  logic [W-1:0]      w_enc_neg;
  logic [W-1:0]      w_enc_zero;

  // Zero-extend before negating so the full magnitude range stays legal.
  assign w_amp_pos  = {1'b0, cfg_amp};
  assign w_amp_neg  = -w_amp_pos;
  assign w_enc_pos  = W'(encode(16'(w_amp_pos), W));
  assign w_enc_neg  = W'(encode(16'(w_amp_neg), W));
  assign w_enc_zero = W'(encode(16'h0000, W));

  prbs_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_prbs_gen (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .cfg_div      (cfg_div),
    .cfg_prbs_sel (cfg_prbs_sel),
    .prbs_restart (prbs_restart),
    .prbs_bit     (w_prbs_bit),
    .prbs_wrap    (prbs_wrap)
  );

  assign w_accept    = s_axis.tvalid & r_tready;
  assign w_underflow = r_tready & ~s_axis.tvalid & (|w_is_stream);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_tready        <= 1'b0;
      r_dac_rst       <= 1'b1;
      r_underflow_cnt <= '0;
    end else begin
      r_tready  <= 1'b1;
      r_dac_rst <= 1'b0;
      if (cnt_clr) begin
        r_underflow_cnt <= '0;
      end else if (w_underflow && (r_underflow_cnt != 32'hFFFF_FFFF)) begin
        r_underflow_cnt <= r_underflow_cnt + 32'd1;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    dac_mode_e    w_mode;
    logic [W-1:0] w_lane_enc;
    logic [W-1:0] w_word_next;
    logic [W-1:0] r_word;

    assign w_mode         = dac_mode_e'(cfg_mode[2*i +: 2]);
    assign w_is_stream[i] = (w_mode == MODE_STREAM);
    // encode() drops the unused upper lane bits.
    assign w_lane_enc     = W'(encode(s_axis.tdata[16*i +: 16], W));

    always_comb begin
      w_word_next = w_enc_zero;
      case (w_mode)
        MODE_STREAM: begin
          if (w_accept) begin
            w_word_next = w_lane_enc;
          end else if (cfg_hold_en) begin
            w_word_next = r_word;
          end
        end
        MODE_PRBS:  w_word_next = w_prbs_bit ? w_enc_pos : w_enc_neg;
        MODE_CONST: w_word_next = w_enc_pos;
        default:    w_word_next = w_enc_zero;
      endcase
    end

    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        r_word <= w_enc_zero;
      end else begin
        r_word <= w_word_next;
      end
    end

    assign dac_dat[i*W +: W] = r_word;
  end

  assign s_axis.tready = r_tready;
  assign dac_rst       = r_dac_rst;
  assign prbs_bit      = w_prbs_bit;
  assign underflow_cnt = r_underflow_cnt;

endmodule
`default_nettype wire
